// File: rtl/fifo_burst_writer_pkg.sv
// Shared types and default constants for the FIFO burst writer.
package fifo_burst_pkg;

  localparam int unsigned FBW_WIDTH     = 8;
  localparam int unsigned FBW_LOG_DEPTH = 3;
  localparam int unsigned FBW_BURST_LEN = 4;
  localparam int unsigned FBW_TIMEOUT   = 15;

  // Two-state writer FSM; the top maps these onto plain localparam constants.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fbw_state_e;

  // Width of a counter that must reach max_val without wrapping (at least 1 bit).
  function automatic int unsigned fbw_cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_writer_if.sv
// Upstream stream handshake plus FIFO write-side signals of the burst writer.
// master: the side driving the stream and modelling the FIFO; slave: the writer.
interface fifo_burst_writer_if
  import fifo_burst_pkg::*;
#(
  parameter int unsigned WIDTH     = FBW_WIDTH,
  parameter int unsigned LOG_DEPTH = FBW_LOG_DEPTH
);

  logic                 s_valid;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 s_ready;
  logic                 wrreq;
  logic [WIDTH-1:0]     wr_data;
  logic                 wrfull;
  logic [LOG_DEPTH-1:0] wrusedw;

  modport master (
    output s_valid, s_data, s_last, wrfull, wrusedw,
    input  s_ready, wrreq, wr_data
  );

  modport slave (
    input  s_valid, s_data, s_last, wrfull, wrusedw,
    output s_ready, wrreq, wr_data
  );

endinterface

// File: rtl/fifo_burst_writer_stats.sv
// Burst/stall statistics for the FIFO burst writer. Only instantiated when
// FIFO_BURST_WRITER_STATS_EN is defined.
module fbw_stats (
  input  logic        wrclk,
  input  logic        aclr,
  input  logic        i_burst_close,
  input  logic        i_stall,
  output logic [15:0] o_burst_count,
  output logic [15:0] o_stall_count
);

  logic [15:0] r_burst_count;
  logic [15:0] r_stall_count;

  // Burst count wraps; stall count saturates so a long stall never reads as short.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_burst_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (i_burst_close) begin
        r_burst_count <= r_burst_count + 16'd1;
      end
      if (i_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign o_burst_count = r_burst_count;
  assign o_stall_count = r_stall_count;

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst writer into an async FIFO: reserves BURST_LEN free words before opening
// a burst, then forwards up to BURST_LEN beats one cycle late as registered
// writes. A burst closes on BURST_LEN beats, on s_last, or after TIMEOUT idle
// cycles. Define FIFO_BURST_WRITER_STATS_EN to add burst_count/stall_count.
module fifo_burst_writer
  import fifo_burst_pkg::*;
#(
  parameter int unsigned WIDTH     = FBW_WIDTH,
  parameter int unsigned LOG_DEPTH = FBW_LOG_DEPTH,
  parameter int unsigned NUM_WORDS = (2 ** LOG_DEPTH) - 1,
  parameter int unsigned BURST_LEN = FBW_BURST_LEN,
  parameter int unsigned TIMEOUT   = FBW_TIMEOUT
) (
  input  logic                wrclk,
  input  logic                aclr,
  fifo_burst_writer_if.slave  bus,
  output logic                burst_active
`ifdef FIFO_BURST_WRITER_STATS_EN
  ,
  output logic [15:0]         burst_count,
  output logic [15:0]         stall_count
`endif
);

  localparam logic [0:0]  ST_IDLE  = 1'(IDLE);
  localparam logic [0:0]  ST_BURST = 1'(BURST);

  localparam int unsigned UsedW = LOG_DEPTH + 1;
  localparam int unsigned IdleW = fbw_cnt_width(TIMEOUT);

  localparam logic [UsedW-1:0] NumWordsW = UsedW'(NUM_WORDS);
  localparam logic [UsedW-1:0] BurstLenW = UsedW'(BURST_LEN);
  localparam logic [IdleW-1:0] IdleLastW = IdleW'(TIMEOUT - 1);

  if ((BURST_LEN < 1) || (BURST_LEN > NUM_WORDS) || (LOG_DEPTH < 2)) begin : g_param_check
    $error("fifo_burst_writer: need 1 <= BURST_LEN <= NUM_WORDS and LOG_DEPTH >= 2");
  end

  logic [0:0]       r_state;
  logic [0:0]       w_state_d;
  logic [7:0]       r_beat_cnt;
  logic [7:0]       w_beat_cnt_d;
  logic [IdleW-1:0] r_idle_cnt;
  logic [IdleW-1:0] w_idle_cnt_d;
  logic             r_wrreq;
  logic [WIDTH-1:0] r_wr_data;

  logic [UsedW-1:0] w_used_eff;
  logic [UsedW-1:0] w_free;
  logic             w_ready;
  logic             w_accept;
  logic             w_len_hit;
  logic             w_burst_close;
  logic             w_stall;

  // The write in flight this cycle is not yet in wrusedw, so count it as used.
  assign w_used_eff = {1'b0, bus.wrusedw} + {{LOG_DEPTH{1'b0}}, r_wrreq};
  assign w_free     = (w_used_eff >= NumWordsW) ? '0 : (NumWordsW - w_used_eff);

  assign w_ready   = (r_state == ST_BURST) && !bus.wrfull;
  assign w_accept  = bus.s_valid && w_ready;
  assign w_len_hit = ((32'(r_beat_cnt) + 32'd1) == BURST_LEN);

  // Next-state, beat/idle counters and the statistic strobes.
  always_comb begin
    w_state_d     = r_state;
    w_beat_cnt_d  = r_beat_cnt;
    w_idle_cnt_d  = r_idle_cnt;
    w_burst_close = 1'b0;
    w_stall       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.s_valid && (w_free >= BurstLenW)) begin
          w_state_d    = ST_BURST;
          w_beat_cnt_d = '0;
          w_idle_cnt_d = '0;
        end else if (bus.s_valid) begin
          w_stall = 1'b1;
        end
      end
      ST_BURST: begin
        if (w_accept) begin
          w_beat_cnt_d = r_beat_cnt + 8'd1;
          w_idle_cnt_d = '0;
          // Length and s_last on the same beat are one close, not two.
          if (w_len_hit || bus.s_last) begin
            w_state_d     = ST_IDLE;
            w_burst_close = 1'b1;
          end
        end else begin
          w_idle_cnt_d = r_idle_cnt + 1'b1;
          if (r_idle_cnt == IdleLastW) begin
            w_state_d     = ST_IDLE;
            w_burst_close = 1'b1;
          end
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered FIFO write port; wr_data only moves on an accepted beat.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_wrreq    <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_wrreq    <= w_accept;
      if (w_accept) begin
        r_wr_data <= bus.s_data;
      end
    end
  end

  assign bus.s_ready   = w_ready;
  assign bus.wrreq     = r_wrreq;
  assign bus.wr_data   = r_wr_data;
  assign burst_active  = (r_state == ST_BURST);

  // Space reservation should make a write after a full-flag accept impossible.
  a_no_write_after_full: assert property (
    @(posedge wrclk) disable iff (aclr) (bus.wrfull && w_accept) |=> !bus.wrreq
  );

`ifdef FIFO_BURST_WRITER_STATS_EN
  fbw_stats u_stats (
    .wrclk         (wrclk),
    .aclr          (aclr),
    .i_burst_close (w_burst_close),
    .i_stall       (w_stall),
    .o_burst_count (burst_count),
    .o_stall_count (stall_count)
  );
`else
  logic w_stats_unused;
  assign w_stats_unused = w_burst_close ^ w_stall;
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Randomized scoreboard bench for fifo_burst_writer with a behavioural FIFO
// environment and a burst-rule reference model.
module tb_fifo_burst_writer;

  localparam int NW = 7;
  localparam int BL = 4;
  localparam int TO = 15;

  logic clk;
  logic aclr;
  logic burst_active;
`ifdef FIFO_BURST_WRITER_STATS_EN
  logic [15:0] burst_count;
  logic [15:0] stall_count;
`endif

  fifo_burst_writer_if #(.WIDTH(8), .LOG_DEPTH(3)) bus ();

  fifo_burst_writer #(
    .WIDTH     (8),
    .LOG_DEPTH (3),
    .NUM_WORDS (NW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .wrclk        (clk),
    .aclr         (aclr),
    .bus          (bus),
    .burst_active (burst_active)
`ifdef FIFO_BURST_WRITER_STATS_EN
    ,
    .burst_count  (burst_count),
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO environment
  int   occ     = 0;
  logic pend_wr = 1'b0;
  int   rd_pct  = 0;

  // Reference model
  logic        m_burst   = 1'b0;
  int          m_beats   = 0;
  int          m_idle    = 0;
  logic        m_wr_pend = 1'b0;
  logic [15:0] m_bursts  = '0;
  logic [15:0] m_stall   = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_wd   = '0;
  int          n_writes  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected beat, one cycle after acceptance.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wrreq === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.wr_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(bus.wr_data), 32'(e));
          last_wd = e;
        end
      end else begin
        chk("missing_write_qsize", 32'(exp_q.size()), 32'd0);
        while (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end
        chk("wr_data_hold", 32'(bus.wr_data), 32'(last_wd));
      end
    end
  end

  // One cycle: update FIFO environment, drive inputs, check, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic l, output logic acc);
    int   free_i;
    logic exp_ready;
    @(negedge clk);
    occ = occ + (pend_wr ? 1 : 0);
    if (occ > 0 && int'($urandom_range(0, 99)) < rd_pct) occ--;
    pend_wr     = bus.wrreq;
    bus.wrusedw = 3'(occ);
    bus.wrfull  = (occ >= NW);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    #1;
    free_i = NW - (occ + (m_wr_pend ? 1 : 0));
    if (free_i < 0) free_i = 0;
    exp_ready = m_burst && !bus.wrfull;
    chk("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    chk("burst_active", 32'(burst_active), 32'(m_burst));
    chk("occupancy_le_7", 32'(occ <= NW), 32'd1);
    chk("wrreq_while_full", 32'(bus.wrreq && bus.wrfull), 32'd0);
`ifdef FIFO_BURST_WRITER_STATS_EN
    chk("burst_count", 32'(burst_count), 32'(m_bursts));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    acc = v && exp_ready;
    if (acc) exp_q.push_back(d);
    if (!m_burst) begin
      if (v && free_i >= BL) begin
        m_burst = 1'b1;
        m_beats = 0;
        m_idle  = 0;
      end else if (v && m_stall != 16'hFFFF) begin
        m_stall++;
      end
    end else if (acc) begin
      m_beats++;
      m_idle = 0;
      if (m_beats == BL || l) begin
        m_burst = 1'b0;
        m_bursts++;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_burst = 1'b0;
        m_bursts++;
      end
    end
    m_wr_pend = acc;
  endtask

  // Asynchronous reset pulse placed mid-cycle, just after a step.
  task automatic reset_pulse();
    #2;
    aclr = 1'b1;
    bus.s_valid = 1'b0;
    #1;
    chk("rst_wrreq", 32'(bus.wrreq), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_burst_active", 32'(burst_active), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
`ifdef FIFO_BURST_WRITER_STATS_EN
    chk("rst_burst_count", 32'(burst_count), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    exp_q.delete();
    last_wd   = '0;
    pend_wr   = 1'b0;
    m_burst   = 1'b0;
    m_wr_pend = 1'b0;
    m_bursts  = '0;
    m_stall   = '0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
  endtask

  // Send beats with data held until accepted; s_last on beat index last_at.
  task automatic stream(input logic [7:0] first, input int beats, input int last_at);
    logic [7:0] d;
    int         k;
    logic       acc;
    d = first;
    k = 0;
    for (int i = 0; i < 60 && k < beats; i++) begin
      step(1'b1, d, (k == last_at), acc);
      if (acc) begin
        d++;
        k++;
      end
    end
    chk("stream_beats_accepted", 32'(k), 32'(beats));
  endtask

  task automatic idle_steps(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, acc);
  endtask

  initial begin
    int   w0;
    int   v_pct;
    logic acc;
    aclr        = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.wrfull  = 1'b0;
    bus.wrusedw = '0;
    #1;
    aclr = 1'b1;
    bus.s_valid = 1'b1;
    #6;
    chk("init_wrreq", 32'(bus.wrreq), 32'd0);
    chk("init_s_ready", 32'(bus.s_ready), 32'd0);
    chk("init_burst_active", 32'(burst_active), 32'd0);
    chk("init_wr_data", 32'(bus.wr_data), 32'd0);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;

    // Empty FIFO, stream 0x10..0x13: four writes, then back to IDLE.
    w0 = n_writes;
    stream(8'h10, 4, -1);
    idle_steps(3);
    chk("empty_fifo_writes", 32'(n_writes - w0), 32'd4);
    chk("empty_fifo_idle", 32'(burst_active), 32'd0);

    // wrusedw=4 (free=3): stall for 5 cycles, then wrusedw=3 opens the burst.
    step(1'b0, 8'h00, 1'b0, acc);
    reset_pulse();
    occ = 4;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h20, 1'b0, acc);
    chk("stall_no_burst", 32'(burst_active), 32'd0);
    occ = 3;
    w0 = n_writes;
    stream(8'h20, 4, -1);
    idle_steps(3);
    chk("after_stall_writes", 32'(n_writes - w0), 32'd4);
`ifdef FIFO_BURST_WRITER_STATS_EN
    chk("stall_count_5", 32'(stall_count), 32'd5);
    chk("burst_count_1", 32'(burst_count), 32'd1);
`endif

    // s_last on beat 2 closes after two writes.
    occ = 0;
    w0 = n_writes;
    stream(8'h30, 2, 1);
    idle_steps(3);
    chk("slast_writes", 32'(n_writes - w0), 32'd2);
    chk("slast_idle", 32'(burst_active), 32'd0);
`ifdef FIFO_BURST_WRITER_STATS_EN
    chk("burst_count_2", 32'(burst_count), 32'd2);
`endif

    // One beat then 15 idle cycles: still BURST after 15, IDLE after the 16th step.
    occ = 0;
    w0 = n_writes;
    stream(8'h40, 1, -1);
    idle_steps(15);
    chk("timeout_still_active", 32'(burst_active), 32'd1);
    idle_steps(1);
    chk("timeout_exit", 32'(burst_active), 32'd0);
    chk("timeout_writes", 32'(n_writes - w0), 32'd1);

    // Reset after beat 2 of 4: no further writes.
    occ = 0;
    w0 = n_writes;
    stream(8'h50, 2, -1);
    step(1'b0, 8'h00, 1'b0, acc);
    reset_pulse();
    idle_steps(4);
    chk("reset_mid_writes", 32'(n_writes - w0), 32'd2);
    chk("reset_mid_idle", 32'(burst_active), 32'd0);

    // Reader stalled, continuous stream: one burst fits, then permanent stall.
    occ = 0;
    rd_pct = 0;
    w0 = n_writes;
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0, acc);
    chk("stalled_reader_writes", 32'(n_writes - w0), 32'(BL));
    chk("stalled_reader_occ", 32'(occ), 32'(BL));

    // Randomized traffic with varying load, reader rate and occasional resets.
    for (int seg = 0; seg < 12; seg++) begin
      v_pct  = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 50 : 90);
      rd_pct = int'($urandom_range(0, 100));
      for (int i = 0; i < 120; i++) begin
        step(($urandom_range(0, 99) < v_pct), 8'($urandom), ($urandom_range(0, 9) == 0), acc);
        if ($urandom_range(0, 399) == 0) reset_pulse();
      end
    end

    rd_pct = 100;
    idle_steps(20);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
